max_pool_2x2: RTL

- Streaming 2x2, stride-2 max-pooling stage placed directly downstream of the ReLU stage.
- Consumes rectified activations in raster order, one per accepted cycle.
- Emits one pooled maximum per 2x2 window with a valid strobe, and flags end of frame.
- Holds a half-width line buffer of horizontal pair maxima from even rows.

---
 rtl/max_pool_2x2_pkg.sv | 10 +
 rtl/max_pool_2x2_pool_line_buffer.sv | 26 ++
 rtl/max_pool_2x2.sv | 111 +++++++++++
 3 files changed

// File: rtl/max_pool_2x2_pkg.sv
// Shared widths and default geometry for the 2x2 max-pooling stage.
// The data width follows the ReLU output so the two stages chain without adaptation.
package max_pool_2x2_pkg;

  localparam int RELU_DATA_WIDTH = 24;
  localparam int POOL_DATA_WIDTH = RELU_DATA_WIDTH;
  localparam int POOL_IMG_WIDTH  = 8;
  localparam int POOL_IMG_HEIGHT = 8;

endpackage

// File: rtl/max_pool_2x2_pool_line_buffer.sv
// Half-width store of horizontal pair maxima from the even row of each window pair.
// Asynchronous read keeps the window result available in the same cycle as the bottom-right pixel.
module pool_line_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 4,
  parameter int ADDR_BITS  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  wr_en_i,
  input  logic [ADDR_BITS-1:0]  wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_BITS-1:0]  rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pool over a raster-order activation stream.
// Emits one registered maximum per window and flags the last window of each frame.
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int IMG_WIDTH  = POOL_IMG_WIDTH,
  parameter int IMG_HEIGHT = POOL_IMG_HEIGHT,
  parameter int COL_BITS   = $clog2(IMG_WIDTH),
  parameter int ROW_BITS   = $clog2(IMG_HEIGHT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  pool_in_valid,
  input  logic [DATA_WIDTH-1:0] pool_in,
  output logic                  pool_out_valid,
  output logic [DATA_WIDTH-1:0] pool_out,
  output logic                  frame_done
);

  localparam int HALF_WIDTH   = IMG_WIDTH / 2;
  localparam int LB_ADDR_BITS = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);

  logic [COL_BITS-1:0]     col_q, col_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [DATA_WIDTH-1:0]   hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   pool_out_q, pool_out_d;
  logic                    pool_out_valid_q, pool_out_valid_d;
  logic                    frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0]   pair;
  logic [DATA_WIDTH-1:0]   lb_rd_data;
  logic [DATA_WIDTH-1:0]   win_max;
  logic [LB_ADDR_BITS-1:0] lb_addr;
  logic                    lb_wr_en;
  logic                    col_last, row_last, col_odd, row_odd;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];

  // Each pair of columns shares one line-buffer slot.
  assign lb_addr  = LB_ADDR_BITS'(col_q >> 1);
  assign pair     = (pool_in > hold_q) ? pool_in : hold_q;
  assign win_max  = (lb_rd_data > pair) ? lb_rd_data : pair;
  assign lb_wr_en = pool_in_valid && !reset && col_odd && !row_odd;

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (HALF_WIDTH),
    .ADDR_BITS  (LB_ADDR_BITS)
  ) u_line_buffer (
    .clock     (clock),
    .wr_en_i   (lb_wr_en),
    .wr_addr_i (lb_addr),
    .wr_data_i (pair),
    .rd_addr_i (lb_addr),
    .rd_data_o (lb_rd_data)
  );

  always_comb begin
    col_d            = col_q;
    row_d            = row_q;
    hold_d           = hold_q;
    pool_out_d       = pool_out_q;
    pool_out_valid_d = 1'b0;
    frame_done_d     = 1'b0;
    if (pool_in_valid) begin
      if (!col_odd) begin
        hold_d = pool_in;
      end
      if (col_odd && row_odd) begin
        pool_out_d       = win_max;
        pool_out_valid_d = 1'b1;
        frame_done_d     = col_last && row_last;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q            <= '0;
      row_q            <= '0;
      hold_q           <= '0;
      pool_out_q       <= '0;
      pool_out_valid_q <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      col_q            <= col_d;
      row_q            <= row_d;
      hold_q           <= hold_d;
      pool_out_q       <= pool_out_d;
      pool_out_valid_q <= pool_out_valid_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign pool_out       = pool_out_q;
  assign pool_out_valid = pool_out_valid_q;
  assign frame_done     = frame_done_q;

endmodule
